// File: rtl/adder2_32bit_adder_if.sv
// Operand/result bundle for the 32-bit CLA adder.
// Slave side is the adder; master side drives operands and consumes results.
interface adder2_32bit_adder_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic             in_valid;
    logic [WIDTH-1:0] sum;
    logic             carry_out;
    logic [WIDTH-1:0] sum_q;
    logic             carry_q;
    logic             overflow_q;
    logic             zero_q;
    logic             out_valid;

    modport master (
        output a_in, b_in, in_valid,
        input  sum, carry_out, sum_q, carry_q, overflow_q, zero_q, out_valid
    );

    modport slave (
        input  a_in, b_in, in_valid,
        output sum, carry_out, sum_q, carry_q, overflow_q, zero_q, out_valid
    );
endinterface

// File: rtl/adder2_32bit_adder.sv
// Two-operand adder built from rippled 4-bit CLA groups, plus a status register stage.
// Latency: sum/carry_out 0 cycles, *_q 1 cycle; no backpressure, status holds when in_valid is low.
module adder2_32bit_adder #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    adder2_32bit_adder_if.slave  bus
);
    localparam int NGRP = WIDTH / 4;

    logic [NGRP:0]    grp_c;
    logic [WIDTH-1:0] sum_w;
    logic             overflow;

    assign grp_c[0] = 1'b0;

    for (genvar k = 0; k < NGRP; k++) begin : g_grp
        logic [3:0] g;
        logic [3:0] p;
        logic [4:0] c;

        assign g    = bus.a_in[4*k +: 4] & bus.b_in[4*k +: 4];
        assign p    = bus.a_in[4*k +: 4] ^ bus.b_in[4*k +: 4];
        assign c[0] = grp_c[k];
        assign c[1] = g[0] | (p[0] & c[0]);
        assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
        assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                    | (p[2] & p[1] & p[0] & c[0]);
        assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                    | (p[3] & p[2] & p[1] & g[0])
                    | (p[3] & p[2] & p[1] & p[0] & c[0]);

        assign sum_w[4*k +: 4] = p ^ c[3:0];
        assign grp_c[k+1]      = c[4];
    end

    assign bus.sum       = sum_w;
    assign bus.carry_out = grp_c[NGRP];

    // Same-sign operands producing an opposite-sign result is a signed overflow.
    assign overflow = (bus.a_in[WIDTH-1] == bus.b_in[WIDTH-1])
                   && (sum_w[WIDTH-1] != bus.a_in[WIDTH-1]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.sum_q      <= '0;
            bus.carry_q    <= 1'b0;
            bus.overflow_q <= 1'b0;
            bus.zero_q     <= 1'b0;
            bus.out_valid  <= 1'b0;
        end else begin
            bus.out_valid <= bus.in_valid;
            if (bus.in_valid) begin
                bus.sum_q      <= sum_w;
                bus.carry_q    <= grp_c[NGRP];
                bus.overflow_q <= overflow;
                bus.zero_q     <= (sum_w == '0);
            end
        end
    end
endmodule

// File: tb/tb_adder2_32bit_adder.sv
// Scoreboard bench: stimulus pushes expected status words, a negedge monitor pops on out_valid.
module tb_adder2_32bit_adder;
    typedef struct packed {
        logic [31:0] s;
        logic        c;
        logic        v;
        logic        z;
    } exp_t;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        exp_t        e;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];

    adder2_32bit_adder_if #(.WIDTH(32)) bus ();

    adder2_32bit_adder #(.WIDTH(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, req);
        end
    endtask

    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b);
        logic [32:0] t;
        exp_t r;
        t   = {1'b0, a} + {1'b0, b};
        r.s = t[31:0];
        r.c = t[32];
        r.v = (a[31] == b[31]) && (t[31] != a[31]);
        r.z = (t[31:0] == 32'd0);
        return r;
    endfunction

    // Drive one operand pair at the current negedge and check the combinational side.
    task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic vld,
                         input exp_t e, input string tag);
        bus.a_in     = a;
        bus.b_in     = b;
        bus.in_valid = vld;
        if (vld) sb.push_back(e);
        #1;
        chk({tag, " sum"},   bus.sum,              e.s);
        chk({tag, " carry"}, {31'd0, bus.carry_out}, {31'd0, e.c});
    endtask

    always @(negedge clk) begin
        if (rst_n === 1'b1 && bus.out_valid === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected out_valid: got 1 expected 0");
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("sum_q",      bus.sum_q,               e.s);
                chk("carry_q",    {31'd0, bus.carry_q},    {31'd0, e.c});
                chk("overflow_q", {31'd0, bus.overflow_q}, {31'd0, e.v});
                chk("zero_q",     {31'd0, bus.zero_q},     {31'd0, e.z});
            end
        end
    end

    vec_t dir[10] = '{
        '{32'hFFFF_FFFF, 32'h0000_0001, '{32'h0000_0000, 1'b1, 1'b0, 1'b1}},
        '{32'h7FFF_FFFF, 32'h0000_0001, '{32'h8000_0000, 1'b0, 1'b1, 1'b0}},
        '{32'h8000_0000, 32'h8000_0000, '{32'h0000_0000, 1'b1, 1'b1, 1'b1}},
        '{32'h8000_0000, 32'hFFFF_FFFF, '{32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0}},
        '{32'h1234_5678, 32'h9ABC_DEF0, '{32'hACF1_3568, 1'b0, 1'b0, 1'b0}},
        '{32'hFFFF_FFFF, 32'hFFFF_FFFF, '{32'hFFFF_FFFE, 1'b1, 1'b0, 1'b0}},
        '{32'h0000_0000, 32'h0000_0000, '{32'h0000_0000, 1'b0, 1'b0, 1'b1}},
        '{32'h0F0F_0F0F, 32'hF0F0_F0F1, '{32'h0000_0000, 1'b1, 1'b0, 1'b1}},
        '{32'h4000_0000, 32'h4000_0000, '{32'h8000_0000, 1'b0, 1'b1, 1'b0}},
        '{32'h0000_0003, 32'h0000_0004, '{32'h0000_0007, 1'b0, 1'b0, 1'b0}}
    };

    initial begin
        exp_t e;
        logic [31:0] ra, rb;
        logic        rv;

        // Reset with live inputs: registers clear, sum still tracks.
        rst_n        = 1'b0;
        bus.a_in     = 32'd5;
        bus.b_in     = 32'd7;
        bus.in_valid = 1'b1;
        #1;
        chk("reset sum",        bus.sum,                  32'd12);
        repeat (2) @(negedge clk);
        chk("reset sum_q",      bus.sum_q,                32'd0);
        chk("reset carry_q",    {31'd0, bus.carry_q},     32'd0);
        chk("reset overflow_q", {31'd0, bus.overflow_q},  32'd0);
        chk("reset zero_q",     {31'd0, bus.zero_q},      32'd0);
        chk("reset out_valid",  {31'd0, bus.out_valid},   32'd0);
        bus.in_valid = 1'b0;
        rst_n        = 1'b1;

        // Directed vectors, back-to-back captures.
        foreach (dir[i]) begin
            @(negedge clk);
            drive(dir[i].a, dir[i].b, 1'b1, dir[i].e, $sformatf("dir%0d", i));
        end

        // Hold: last directed vector captured 3+4; now idle with new operands.
        @(negedge clk);
        drive(32'd100, 32'd200, 1'b0, '{32'd300, 1'b0, 1'b0, 1'b0}, "hold");
        repeat (3) @(negedge clk);
        chk("hold sum",       bus.sum,                32'd300);
        chk("hold sum_q",     bus.sum_q,              32'd7);
        chk("hold out_valid", {31'd0, bus.out_valid}, 32'd0);

        // Combinational sweep: i + (i+1) = 2i+1 with no carry.
        for (int i = 0; i < 10100; i++) begin
            @(negedge clk);
            drive(i, i + 1, 1'b0, '{2 * i + 1, 1'b0, 1'b0, 1'b0}, "sweep");
        end

        // Random pairs with toggling in_valid against a 33-bit reference.
        for (int i = 0; i < 10000; i++) begin
            @(negedge clk);
            ra = $urandom;
            rb = $urandom;
            rv = 1'($urandom_range(0, 1));
            drive(ra, rb, rv, model(ra, rb), "rand");
        end

        // Mid-operation reset must clear registers before the next edge.
        @(negedge clk);
        drive(32'hFFFF_FFFF, 32'h0000_0001, 1'b1, '{32'd0, 1'b1, 1'b0, 1'b1}, "pre_rst");
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async rst out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("async rst carry_q",   {31'd0, bus.carry_q},   32'd0);
        chk("async rst zero_q",    {31'd0, bus.zero_q},    32'd0);
        void'(sb.pop_front());
        bus.a_in = 32'd20;
        bus.b_in = 32'd22;
        #1;
        chk("rst track sum", bus.sum, 32'd42);
        @(negedge clk);
        bus.in_valid = 1'b0;
        rst_n        = 1'b1;
        @(negedge clk);
        drive(32'h7FFF_FFFF, 32'h0000_0001, 1'b1, '{32'h8000_0000, 1'b0, 1'b1, 1'b0}, "post_rst");
        @(negedge clk);
        bus.in_valid = 1'b0;

        repeat (3) @(negedge clk);
        chk("scoreboard drained", sb.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/adder2_32bit_adder.md
Name: adder2_32bit_adder

Overview:
- 32-bit two-operand integer adder used in the LEGv8 datapath, for example PC+4 and branch-target generation.
- Sum output is purely combinational, so it settles within one stimulus step of an input change.
- A registered status stage captures the sum, carry, overflow, zero and valid flags for clocked consumers.
- Internal structure is 4-bit carry-lookahead groups rippled group-to-group; no `+` operator on the full word.

Parameters:
- WIDTH, 32, operand and sum width in bits; must be a multiple of 4.

Ports:
- clk  input  1  rising-edge clock for the status register stage.
- rst_n  input  1  asynchronous active-low reset.
- a_in  input  WIDTH  operand A; unsigned or two's complement.
- b_in  input  WIDTH  operand B.
- in_valid  input  1  qualifies a_in/b_in for capture into the registered stage.
- sum  output  WIDTH  combinational (a_in + b_in) mod 2^WIDTH.
- carry_out  output  1  combinational carry out of the MSB.
- sum_q  output  WIDTH  registered sum.
- carry_q  output  1  registered carry out.
- overflow_q  output  1  registered signed overflow.
- zero_q  output  1  registered flag, 1 when the sum is 0.
- out_valid  output  1  registered in_valid.

Behaviour:
- sum and carry_out:
  - Pure combinational function of a_in and b_in; no dependence on clk, rst_n or in_valid.
  - No latches and no combinational loops.
  - sum = low WIDTH bits of a_in + b_in; carry_out = bit WIDTH of the exact sum.
- Carry-lookahead structure:
  - Each 4-bit group computes per-bit generate g = a & b and propagate p = a ^ b.
  - Group carries: c1 = g0 | p0·cin, c2 = g1 | p1·g0 | p1·p0·cin, and so on through c4.
  - Group carry-out feeds the next group's cin; cin of group 0 = 0.
  - Sum bit = p ^ carry-in of that bit.
- Signed overflow (internal, combinational) = (a_in[MSB] == b_in[MSB]) && (sum[MSB] != a_in[MSB]).
- Registered stage, asynchronous reset:
  - On rst_n low, immediately: sum_q = 0, carry_q = 0, overflow_q = 0, zero_q = 0, out_valid = 0.
  - Holds those values while rst_n is low, regardless of clk.
- Registered stage, on each rising clk edge with rst_n high:
  - out_valid <= in_valid.
  - If in_valid = 1: sum_q <= sum, carry_q <= carry_out, overflow_q <= overflow, zero_q <= (sum == 0).
  - If in_valid = 0: sum_q, carry_q, overflow_q and zero_q hold their previous values.
- Latency: combinational outputs 0 cycles; registered outputs 1 cycle after the capturing edge.
- Boundary conditions:
  - Wrap-around: 0xFFFFFFFF + 1 gives sum = 0, carry = 1, overflow = 0, zero = 1.
  - 0x7FFFFFFF + 1 gives sum = 0x80000000, carry = 0, overflow = 1.
  - 0x80000000 + 0x80000000 gives sum = 0, carry = 1, overflow = 1.
- Reset mid-operation:
  - Registered outputs clear asynchronously.
  - Combinational sum continues to track the inputs.
  - The first capture after release is the first rising edge with rst_n high and in_valid = 1.
- Release of rst_n is synchronised externally; no internal synchroniser is required.

Test Plan:
- Reset: rst_n = 0 with a_in = 5, b_in = 7, in_valid = 1 -> all registered outputs 0, out_valid = 0; sum = 12 combinationally.
- Sweep: for i = 0..10099 drive a_in = i, b_in = i+1, wait 10 ns -> sum == 2i+1 and carry_out = 0 for every i; any mismatch flagged as an error.
- Wrap and carry: a_in = 0xFFFFFFFF, b_in = 1, in_valid = 1, one clock -> sum = 0, carry_out = 1; sum_q = 0, carry_q = 1, zero_q = 1, overflow_q = 0, out_valid = 1.
- Signed overflow:
  - 0x7FFFFFFF + 1 -> overflow_q = 1, sum_q = 0x80000000.
  - 0x80000000 + 0xFFFFFFFF -> sum = 0x7FFFFFFF, carry = 1, overflow_q = 1.
- Hold: capture 3 + 4 (sum_q = 7), then in_valid = 0 with a_in = 100, b_in = 200 for 3 clocks -> sum = 300 combinationally, sum_q stays 7, out_valid = 0.
- Random: 10,000 random a_in/b_in pairs with in_valid toggling -> sum, carry_out and the registered flags match the 33-bit reference model every cycle.
